// File: rtl/bmp_pkg.sv
// ---------------------------------------------------------------------------
// bmp_pkg
//   Shared constants and types for the BMP header copier:
//   - BMP header size and the byte offsets of the fields we decode
//   - expected signature bytes ("BM")
//   - copier FSM state encoding
// ---------------------------------------------------------------------------
package bmp_pkg;

    localparam int HDR_SIZE       = 54;

    // Byte offsets of the decoded header fields (all little-endian)
    localparam int OFS_SIG0       = 0;
    localparam int OFS_SIG1       = 1;
    localparam int OFS_FILE_SIZE  = 2;
    localparam int OFS_PIX_OFFSET = 10;
    localparam int OFS_WIDTH      = 18;
    localparam int OFS_HEIGHT     = 22;
    localparam int OFS_BPP        = 28;

    // Last header byte the validation depends on (high byte of bpp)
    localparam int OFS_VALIDATE   = OFS_BPP + 1;

    localparam logic [7:0] SIG_B  = 8'h42;
    localparam logic [7:0] SIG_M  = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } bmp_state_e;

endpackage

// File: rtl/bmp_le_field.sv
// ---------------------------------------------------------------------------
// bmp_le_field
//   Little-endian byte-lane capture register. When a byte with address
//   BASE+b streams past (i_valid), it is loaded into lane b of the field.
//
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     i_clear       synchronous clear (new transfer accepted)
//     i_valid       i_byte/i_addr carry a byte this cycle
//     i_addr        byte address of i_byte
//     i_byte        streamed byte
//     o_value       registered field value
//     o_value_next  field value including the byte arriving this cycle
// ---------------------------------------------------------------------------
module bmp_le_field #(
    parameter int ADDR_WIDTH = 20,
    parameter int BYTE_WIDTH = 8,
    parameter int BASE       = 0,
    parameter int NBYTES     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_valid,
    input  logic [ADDR_WIDTH-1:0]        i_addr,
    input  logic [BYTE_WIDTH-1:0]        i_byte,
    output logic [NBYTES*BYTE_WIDTH-1:0] o_value,
    output logic [NBYTES*BYTE_WIDTH-1:0] o_value_next
);

    logic [NBYTES*BYTE_WIDTH-1:0] r_value;
    logic [NBYTES*BYTE_WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_value;
        for (int b = 0; b < NBYTES; b++) begin
            if (i_valid && (i_addr == ADDR_WIDTH'(BASE + b))) begin
                w_next[b*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value      = r_value;
    // Bypass lets the header check use a field whose last byte arrives now
    assign o_value_next = w_next;

endmodule

// File: rtl/bmp_header_copier.sv
// ---------------------------------------------------------------------------
// bmp_header_copier
//   Copies a BMP file byte-for-byte from a synchronous ROM (1-cycle read
//   latency) to a RAM at the same address, decoding the header fields as they
//   pass and aborting the copy if the header is not acceptable.
//
//   Handshake: ROM_valid=1 with rom_addr requests a byte; ROM_odata holds it
//   exactly one cycle later, when it is forwarded as a RAM write
//   (RAM_valid/ram_addr/ram_data). There is no back-pressure on either side.
//
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     start                single-cycle start (accepted in IDLE or ERROR)
//     ROM_valid, rom_addr  ROM read request
//     ROM_odata            ROM read data
//     RAM_valid, ram_addr, ram_data  RAM write
//     busy                 copy in progress
//     done                 one-cycle pulse after the last write
//     hdr_error            sticky header-invalid flag
//     file_size, pixel_offset, img_width, img_height, bits_per_pixel
//                          decoded header fields
// ---------------------------------------------------------------------------
module bmp_header_copier
    import bmp_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int BYTE_WIDTH = 8,
    parameter int TOTAL_SIZE = 786486,
    parameter int REQ_BPP    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ROM_valid,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [BYTE_WIDTH-1:0] ROM_odata,
    output logic                  RAM_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BYTE_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic                  hdr_error,
    output logic [31:0]           file_size,
    output logic [31:0]           pixel_offset,
    output logic [31:0]           img_width,
    output logic [31:0]           img_height,
    output logic [15:0]           bits_per_pixel
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);

    bmp_state_e r_state;
    bmp_state_e w_next_state;

    logic                  r_rom_valid;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_rd_pend;     // ROM data for r_ram_addr arrives now
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_hdr_error;
    logic [BYTE_WIDTH-1:0] r_sig0;
    logic [BYTE_WIDTH-1:0] r_sig1;

    logic                  w_start_acc;
    logic                  w_check;
    logic                  w_hdr_bad;
    logic                  w_last_write;

    logic [4*BYTE_WIDTH-1:0] w_fsize_reg, w_fsize_next;
    logic [4*BYTE_WIDTH-1:0] w_pofs_reg,  w_pofs_next;
    logic [4*BYTE_WIDTH-1:0] w_width_reg, w_width_next;
    logic [4*BYTE_WIDTH-1:0] w_height_reg, w_height_next;
    logic [2*BYTE_WIDTH-1:0] w_bpp_reg,   w_bpp_next;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    assign w_start_acc  = start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    assign w_check      = r_rd_pend && (r_ram_addr == ADDR_WIDTH'(OFS_VALIDATE));
    assign w_last_write = r_rd_pend && (r_ram_addr == LAST_ADDR);

    // The bpp high byte is on ROM_odata in the check cycle, so the bypassed
    // value is used; the other fields are complete well before.
    assign w_hdr_bad = w_check &&
                       ((r_sig0 != BYTE_WIDTH'(SIG_B)) ||
                        (r_sig1 != BYTE_WIDTH'(SIG_M)) ||
                        (w_bpp_next != (2*BYTE_WIDTH)'(REQ_BPP)) ||
                        (w_fsize_next != (4*BYTE_WIDTH)'(TOTAL_SIZE)));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_COPY;
            ST_COPY: begin
                // A header failure wins; it can only occur at address 29
                if (w_hdr_bad) begin
                    w_next_state = ST_ERROR;
                end else if (w_last_write) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERROR: if (start) w_next_state = ST_COPY;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read/write datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_valid <= 1'b0;
            r_rom_addr  <= '0;
            r_rd_pend   <= 1'b0;
            r_ram_addr  <= '0;
            r_hdr_error <= 1'b0;
            r_sig0      <= '0;
            r_sig1      <= '0;
        end else begin
            // Dropping r_rd_pend on a failed check discards the byte in flight
            r_rd_pend  <= r_rom_valid && !w_hdr_bad;
            r_ram_addr <= r_rom_addr;

            if (w_start_acc) begin
                r_rom_valid <= 1'b1;
                r_rom_addr  <= '0;
                r_hdr_error <= 1'b0;
                r_sig0      <= '0;
                r_sig1      <= '0;
            end else begin
                if (w_hdr_bad) begin
                    r_rom_valid <= 1'b0;
                    r_hdr_error <= 1'b1;
                end else if (r_rom_valid) begin
                    // Address saturates on the final request
                    if (r_rom_addr == LAST_ADDR) begin
                        r_rom_valid <= 1'b0;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                    end
                end

                if (r_rd_pend && (r_ram_addr == ADDR_WIDTH'(OFS_SIG0))) begin
                    r_sig0 <= ROM_odata;
                end
                if (r_rd_pend && (r_ram_addr == ADDR_WIDTH'(OFS_SIG1))) begin
                    r_sig1 <= ROM_odata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Header field capture
    // ------------------------------------------------------------------
    bmp_le_field #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
                   .BASE(OFS_FILE_SIZE), .NBYTES(4)) u_file_size (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_valid(r_rd_pend),
        .i_addr(r_ram_addr), .i_byte(ROM_odata),
        .o_value(w_fsize_reg), .o_value_next(w_fsize_next)
    );

    bmp_le_field #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
                   .BASE(OFS_PIX_OFFSET), .NBYTES(4)) u_pixel_offset (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_valid(r_rd_pend),
        .i_addr(r_ram_addr), .i_byte(ROM_odata),
        .o_value(w_pofs_reg), .o_value_next(w_pofs_next)
    );

    bmp_le_field #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
                   .BASE(OFS_WIDTH), .NBYTES(4)) u_img_width (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_valid(r_rd_pend),
        .i_addr(r_ram_addr), .i_byte(ROM_odata),
        .o_value(w_width_reg), .o_value_next(w_width_next)
    );

    bmp_le_field #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
                   .BASE(OFS_HEIGHT), .NBYTES(4)) u_img_height (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_valid(r_rd_pend),
        .i_addr(r_ram_addr), .i_byte(ROM_odata),
        .o_value(w_height_reg), .o_value_next(w_height_next)
    );

    bmp_le_field #(.ADDR_WIDTH(ADDR_WIDTH), .BYTE_WIDTH(BYTE_WIDTH),
                   .BASE(OFS_BPP), .NBYTES(2)) u_bpp (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_valid(r_rd_pend),
        .i_addr(r_ram_addr), .i_byte(ROM_odata),
        .o_value(w_bpp_reg), .o_value_next(w_bpp_next)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ROM_valid = r_rom_valid;
    assign rom_addr  = r_rom_addr;
    assign RAM_valid = r_rd_pend;
    assign ram_addr  = r_ram_addr;
    assign ram_data  = r_rd_pend ? ROM_odata : '0;
    assign busy      = (r_state == ST_COPY);
    assign done      = (r_state == ST_DONE);
    assign hdr_error = r_hdr_error;

    // Fields use the bypassed value so the last header byte is visible in
    // the cycle it arrives; after that the bypass equals the register.
    assign file_size      = 32'(w_fsize_next);
    assign pixel_offset   = 32'(w_pofs_next);
    assign img_width      = 32'(w_width_next);
    assign img_height     = 32'(w_height_next);
    assign bits_per_pixel = 16'(w_bpp_next);

    // Registered copies are kept for visibility of the stored state
    logic w_unused;
    assign w_unused = ^{w_fsize_reg, w_pofs_reg, w_width_reg, w_height_reg, w_bpp_reg};

endmodule
